// File: rtl/dram_cmd_sequencer.sv
// rtl/dram_cmd_sequencer.sv - DRAM command sequencer with per-bank open-row tracking and refresh
// Build option DRAM_SEQ_OPEN_PAGE_EN selects open-page policy; undefined gives closed-page.
module dram_cmd_sequencer #(
  parameter int BANKS    = 8,
  parameter int ROW_BITS = 8,
  parameter int COL_BITS = 4,
  parameter int T_RCD    = 3,
  parameter int T_RP     = 3,
  parameter int T_CL     = 4,
  parameter int T_RFC    = 10
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     req_valid_in,
  output logic                     req_ready_out,
  input  logic                     req_we_in,
  input  logic [63:0]              req_addr_in,
  input  logic [63:0]              req_data_in,
  input  logic                     refresh_req_in,
  output logic                     refresh_ack_out,
  output logic                     resp_valid_out,
  output logic [63:0]              resp_data_out,
  output logic                     cs_N_out,
  output logic                     ras_N_out,
  output logic                     cas_N_out,
  output logic                     we_N_out,
  output logic [$clog2(BANKS)-1:0] bank_out,
  output logic [ROW_BITS-1:0]      row_out,
  output logic [COL_BITS-1:0]      col_out,
  output logic                     pall_out,
  output logic [63:0]              dram_wdata_out,
  input  logic [63:0]              dram_value_in
);
  localparam int BB    = $clog2(BANKS);
  localparam int T_A   = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int T_B   = (T_CL > T_RFC) ? T_CL : T_RFC;
  localparam int T_MAX = (T_A > T_B) ? T_A : T_B;
  localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] LD_CL  = CNT_W'(T_CL - 1);
  localparam logic [CNT_W-1:0] LD_RFC = CNT_W'(T_RFC - 1);
  localparam logic [3:0] CMD_NOP = 4'b0111, CMD_ACT = 4'b0011, CMD_RD  = 4'b0101,
                         CMD_WR  = 4'b0100, CMD_PRE = 4'b0010, CMD_REF = 4'b0001,
                         CMD_DES = 4'b1111;

  typedef enum logic [3:0] {
    IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, ACCESS, READ_WAIT,
    REF_PRE, REF_PRE_WAIT, REF, REF_WAIT
  } state_t;

`ifdef DRAM_SEQ_OPEN_PAGE_EN
  localparam state_t AFTER_PRE  = ACT;   // PRE only happens on a row miss
  localparam state_t AFTER_DONE = IDLE;
`else
  localparam state_t AFTER_PRE  = IDLE;  // PRE closes the row after every access
  localparam state_t AFTER_DONE = PRE;
`endif

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d, cnt_dec;
  logic                deselect;
  logic                we_q;
  logic [BB-1:0]       bank_q;
  logic [ROW_BITS-1:0] row_q;
  logic [COL_BITS-1:0] col_q;
  logic [63:0]         data_q;
  logic [BANKS-1:0]    open_q;
  logic [BB-1:0]       req_bank;
  logic [ROW_BITS-1:0] req_row;
  logic [COL_BITS-1:0] req_col;
  logic                accept;
  logic [3:0]          cmd;
  logic                unused_addr;

  assign req_col     = req_addr_in[COL_BITS-1:0];
  assign req_bank    = req_addr_in[COL_BITS +: BB];
  assign req_row     = req_addr_in[COL_BITS+BB +: ROW_BITS];
  assign unused_addr = ^req_addr_in[63:COL_BITS+BB+ROW_BITS];

  assign req_ready_out   = (state == IDLE) && !refresh_req_in && !rst_in;
  assign accept          = req_valid_in && req_ready_out;
  assign cnt_dec         = (cnt == '0) ? '0 : cnt - CNT_W'(1);
  assign resp_valid_out  = (state == READ_WAIT) && (cnt == '0);
  assign resp_data_out   = resp_valid_out ? dram_value_in : '0;
  assign refresh_ack_out = (state == REF_WAIT) && (cnt == '0);
  assign {cs_N_out, ras_N_out, cas_N_out, we_N_out} = cmd;

`ifdef DRAM_SEQ_OPEN_PAGE_EN
  logic [ROW_BITS-1:0] open_row_q [BANKS];
  logic                row_hit;

  assign row_hit = open_q[req_bank] && (open_row_q[req_bank] == req_row);

  always_ff @(posedge clk_in) begin
    if (!rst_in && state == ACT) open_row_q[bank_q] <= row_q;
  end
`endif

  always_comb begin
    state_d = state;
    cnt_d   = cnt_dec;
    case (state)
      IDLE: begin
        if (refresh_req_in) state_d = (|open_q) ? REF_PRE : REF;
        else if (accept) begin
`ifdef DRAM_SEQ_OPEN_PAGE_EN
          if (!open_q[req_bank]) state_d = ACT;
          else if (row_hit)      state_d = ACCESS;
          else                   state_d = PRE;
`else
          state_d = ACT;
`endif
        end
      end
      PRE:          state_d = (cnt == '0) ? AFTER_PRE : PRE_WAIT;
      PRE_WAIT:     if (cnt == '0) state_d = AFTER_PRE;
      ACT:          state_d = (cnt == '0) ? ACCESS : ACT_WAIT;
      ACT_WAIT:     if (cnt == '0) state_d = ACCESS;
      ACCESS:       state_d = we_q ? AFTER_DONE : READ_WAIT;
      READ_WAIT:    if (cnt == '0) state_d = AFTER_DONE;
      REF_PRE:      state_d = (cnt == '0) ? REF : REF_PRE_WAIT;
      REF_PRE_WAIT: if (cnt == '0) state_d = REF;
      REF:          state_d = REF_WAIT;
      REF_WAIT:     if (cnt == '0) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
    // Each timed phase reloads the shared counter when it is entered
    if (state_d != state) begin
      case (state_d)
        ACT:          cnt_d = LD_RCD;
        PRE, REF_PRE: cnt_d = LD_RP;
        READ_WAIT:    cnt_d = LD_CL;
        REF_WAIT:     cnt_d = LD_RFC;
        default:      ;
      endcase
    end
  end

  always_comb begin
    cmd            = CMD_NOP;
    bank_out       = '0;
    row_out        = '0;
    col_out        = '0;
    pall_out       = 1'b0;
    dram_wdata_out = '0;
    case (state)
      PRE: begin
        cmd      = CMD_PRE;
        bank_out = bank_q;
      end
      ACT: begin
        cmd      = CMD_ACT;
        bank_out = bank_q;
        row_out  = row_q;
      end
      ACCESS: begin
        cmd      = we_q ? CMD_WR : CMD_RD;
        bank_out = bank_q;
        col_out  = col_q;
        if (we_q) dram_wdata_out = data_q;
      end
      REF_PRE: begin
        cmd      = CMD_PRE;
        pall_out = 1'b1;
      end
      REF:     cmd = CMD_REF;
      default: ;
    endcase
    // The cycle after a reset edge drives deselect rather than NOP
    if (deselect) begin
      cmd            = CMD_DES;
      bank_out       = '0;
      row_out        = '0;
      col_out        = '0;
      pall_out       = 1'b0;
      dram_wdata_out = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= IDLE;
      cnt      <= '0;
      deselect <= 1'b1;
      open_q   <= '0;
      we_q     <= 1'b0;
      bank_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      data_q   <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      deselect <= 1'b0;
      if (accept) begin
        we_q   <= req_we_in;
        bank_q <= req_bank;
        row_q  <= req_row;
        col_q  <= req_col;
        data_q <= req_data_in;
      end
      if (state == ACT)          open_q[bank_q] <= 1'b1;
      else if (state == PRE)     open_q[bank_q] <= 1'b0;
      else if (state == REF_PRE) open_q         <= '0;
    end
  end
endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// tb/tb_dram_cmd_sequencer.sv - randomized bench with a per-transaction command schedule model
module tb_dram_cmd_sequencer;
  localparam int BANKS = 8, ROW_BITS = 8, COL_BITS = 4;
  localparam int T_RCD = 3, T_RP = 3, T_CL = 4, T_RFC = 10;
  localparam int BB = $clog2(BANKS);
  localparam int MAXOFF = 32;
  localparam int VW = 160;
  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101,
                         C_WR = 4'b0100, C_PRE = 4'b0010, C_REF = 4'b0001, C_DES = 4'b1111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, req_valid, req_ready, req_we, refresh_req, refresh_ack;
  logic [63:0]         req_addr, req_data, resp_data, dram_wdata, dram_value;
  logic                resp_valid, cs_n, ras_n, cas_n, we_n, pall;
  logic [BB-1:0]       bank;
  logic [ROW_BITS-1:0] row;
  logic [COL_BITS-1:0] col;

  dram_cmd_sequencer #(
    .BANKS(BANKS), .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS),
    .T_RCD(T_RCD), .T_RP(T_RP), .T_CL(T_CL), .T_RFC(T_RFC)
  ) dut (
    .clk_in(clk), .rst_in(rst),
    .req_valid_in(req_valid), .req_ready_out(req_ready), .req_we_in(req_we),
    .req_addr_in(req_addr), .req_data_in(req_data),
    .refresh_req_in(refresh_req), .refresh_ack_out(refresh_ack),
    .resp_valid_out(resp_valid), .resp_data_out(resp_data),
    .cs_N_out(cs_n), .ras_N_out(ras_n), .cas_N_out(cas_n), .we_N_out(we_n),
    .bank_out(bank), .row_out(row), .col_out(col), .pall_out(pall),
    .dram_wdata_out(dram_wdata), .dram_value_in(dram_value)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: bank state plus the expected command schedule of one transaction
  bit                  open_m [BANKS];
`ifdef DRAM_SEQ_OPEN_PAGE_EN
  int                  row_m [BANKS];
`endif
  logic [3:0]          e_cmd  [MAXOFF];
  logic [BB-1:0]       e_bank [MAXOFF];
  logic [ROW_BITS-1:0] e_row  [MAXOFF];
  logic [COL_BITS-1:0] e_col  [MAXOFF];
  logic                e_pall [MAXOFF];
  logic [63:0]         e_wd   [MAXOFF];
  int                  e_resp, e_ack, e_end;

  function automatic logic [VW-1:0] pack(input logic [3:0] c, input logic [BB-1:0] b,
      input logic [ROW_BITS-1:0] r, input logic [COL_BITS-1:0] cl, input logic pa,
      input logic [63:0] wd, input logic rv, input logic [63:0] rd, input logic ak,
      input logic rdy);
    return VW'({c, b, r, cl, pa, wd, rv, rd, ak, rdy});
  endfunction

  function automatic logic [VW-1:0] obs();
    return pack({cs_n, ras_n, cas_n, we_n}, bank, row, col, pall, dram_wdata,
                resp_valid, resp_data, refresh_ack, req_ready);
  endfunction

  function automatic logic [VW-1:0] exp_at(input int k, input logic rdy);
    return pack(e_cmd[k], e_bank[k], e_row[k], e_col[k], e_pall[k], e_wd[k],
                k == e_resp, (k == e_resp) ? dram_value : 64'h0, k == e_ack, rdy);
  endfunction

  task automatic clear_sched();
    for (int i = 0; i < MAXOFF; i++) begin
      e_cmd[i] = C_NOP; e_bank[i] = '0; e_row[i] = '0; e_col[i] = '0;
      e_pall[i] = 1'b0; e_wd[i] = '0;
    end
    e_resp = -1; e_ack = -1; e_end = 1;
  endtask

  task automatic put(input int k, input logic [3:0] c, input logic [BB-1:0] b,
      input logic [ROW_BITS-1:0] r, input logic [COL_BITS-1:0] cl, input logic pa,
      input logic [63:0] wd);
    e_cmd[k] = c; e_bank[k] = b; e_row[k] = r; e_col[k] = cl; e_pall[k] = pa; e_wd[k] = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    dram_value = {$urandom, $urandom};
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a = {$urandom, $urandom};
    a[COL_BITS-1:0] = COL_BITS'($urandom);
    a[COL_BITS +: BB] = BB'($urandom_range(0, 2));
    a[COL_BITS+BB +: ROW_BITS] = ROW_BITS'($urandom_range(0, 2));
    return a;
  endfunction

  task automatic do_req(input logic we, input logic [63:0] a, input logic [63:0] d);
    logic [BB-1:0]       b;
    logic [ROW_BITS-1:0] r;
    logic [COL_BITS-1:0] c;
    int acc, last;
    b = a[COL_BITS +: BB];
    r = a[COL_BITS+BB +: ROW_BITS];
    c = a[COL_BITS-1:0];
    clear_sched();
`ifdef DRAM_SEQ_OPEN_PAGE_EN
    if (open_m[b] && row_m[b] == int'(r)) acc = 1;
    else begin
      acc = 1;
      if (open_m[b]) begin put(acc, C_PRE, b, '0, '0, 1'b0, '0); acc += T_RP; end
      put(acc, C_ACT, b, r, '0, 1'b0, '0);
      acc += T_RCD;
    end
`else
    put(1, C_ACT, b, r, '0, 1'b0, '0);
    acc = 1 + T_RCD;
`endif
    put(acc, we ? C_WR : C_RD, b, '0, c, 1'b0, we ? d : 64'h0);
    last = we ? acc : acc + T_CL;
    if (!we) e_resp = last;
`ifdef DRAM_SEQ_OPEN_PAGE_EN
    open_m[b] = 1'b1;
    row_m[b] = int'(r);
    e_end = last + 1;
`else
    put(last + 1, C_PRE, b, '0, '0, 1'b0, '0);
    open_m[b] = 1'b0;
    e_end = last + 1 + T_RP;
`endif
    req_valid = 1'b1; req_we = we; req_addr = a; req_data = d;
    @(negedge clk);
    check("req_accept", obs(), exp_at(0, 1'b1));
    for (int k = 1; k < e_end; k++) begin
      next_cycle();
      req_valid = 1'b0; req_addr = rand_addr(); req_data = {$urandom, $urandom};
      @(negedge clk);
      check($sformatf("req a=%h k=%0d", a, k), obs(), exp_at(k, 1'b0));
    end
    next_cycle();
  endtask

  task automatic do_refresh(input logic with_req);
    bit any;
    int t;
    clear_sched();
    any = 1'b0;
    for (int i = 0; i < BANKS; i++) any |= open_m[i];
    t = 1;
    if (any) begin put(1, C_PRE, '0, '0, '0, 1'b1, '0); t = 1 + T_RP; end
    put(t, C_REF, '0, '0, '0, 1'b0, '0);
    e_ack = t + T_RFC;
    e_end = e_ack + 1;
    for (int i = 0; i < BANKS; i++) open_m[i] = 1'b0;
    refresh_req = 1'b1; req_valid = with_req; req_we = 1'b0; req_addr = rand_addr();
    @(negedge clk);
    check("ref_start", obs(), exp_at(0, 1'b0));
    for (int k = 1; k < e_end; k++) begin
      next_cycle();
      @(negedge clk);
      check($sformatf("ref k=%0d", k), obs(), exp_at(k, 1'b0));
    end
    next_cycle();
    refresh_req = 1'b0; req_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    req_valid = 1'b0;
    clear_sched();
    @(negedge clk);
    check("idle", obs(), exp_at(0, 1'b1));
    next_cycle();
  endtask

  // Read to a closed bank, reset while waiting tRCD: deselect, no response, row forgotten
  task automatic reset_mid_act(input logic [63:0] a);
    clear_sched();
    put(1, C_ACT, a[COL_BITS +: BB], a[COL_BITS+BB +: ROW_BITS], '0, 1'b0, '0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    @(negedge clk);
    check("rm_accept", obs(), exp_at(0, 1'b1));
    next_cycle();
    req_valid = 1'b0;
    @(negedge clk);
    check("rm_act", obs(), exp_at(1, 1'b0));
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rm_wait", obs(), exp_at(2, 1'b0));
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rm_desel", obs(), pack(C_DES, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1));
    for (int i = 0; i < BANKS; i++) open_m[i] = 1'b0;
    next_cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0;
    refresh_req = 1'b0; dram_value = '0;
    for (int i = 0; i < BANKS; i++) open_m[i] = 1'b0;
    clear_sched();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset", obs(), pack(C_DES, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0));
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("post_reset", obs(), pack(C_DES, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1));
    next_cycle();

    do_req(1'b0, 64'h85, {$urandom, $urandom});
    idle_cycle();
    do_req(1'b0, 64'h86, {$urandom, $urandom});
    idle_cycle();
    do_req(1'b1, 64'h105, 64'hDEAD);
    do_refresh(1'b1);
    reset_mid_act(64'h2B2);
    do_req(1'b0, 64'h2B2, {$urandom, $urandom});
    do_refresh(1'b0);

    for (int i = 0; i < 60; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle_cycle();
      if ($urandom_range(0, 7) == 0) do_refresh(1'($urandom_range(0, 1)));
      else do_req(1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
